// File: rtl/arbitro_rr_4.sv
// Round-robin arbiter sharing one ANCHO-bit output among four valid/ready requesters, bursts up to MAX_RAFAGA beats.
// Latency: one cycle request-to-grant, one cycle beat-to-output; one idle cycle between grants.
// Backpressure: a stalled output stage deasserts req_ready of the granted requester; other requesters always wait.
module arbitro_rr_4 #(
    parameter int ANCHO      = 8,
    parameter int MAX_RAFAGA = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_last,
    input  logic [ANCHO-1:0] dat_a,
    input  logic [ANCHO-1:0] dat_b,
    input  logic [ANCHO-1:0] dat_c,
    input  logic [ANCHO-1:0] dat_d,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [ANCHO-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             ocupado
);

    localparam int CW = ($clog2(MAX_RAFAGA + 1) > 1) ? $clog2(MAX_RAFAGA + 1) : 1;

    typedef enum logic {IDLE, GRANT} estado_t;

    estado_t          estado;
    logic [1:0]       puntero;
    logic [CW-1:0]    cuenta;
    logic [1:0]       ganador;
    logic             hay_req;
    logic             acepta;
    logic             transfer;
    logic             fin;
    logic [ANCHO-1:0] dat_sel;

    // Search starts at puntero so the requester after the last winner has priority.
    always_comb begin
        logic [1:0] idx;
        idx     = puntero;
        ganador = puntero;
        hay_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = puntero + 2'(k);
            if (!hay_req && req_valid[idx]) begin
                ganador = idx;
                hay_req = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    dat_sel = dat_a;
            2'd1:    dat_sel = dat_b;
            2'd2:    dat_sel = dat_c;
            default: dat_sel = dat_d;
        endcase
    end

    assign acepta   = !out_valid || out_ready;
    assign ocupado  = (estado == GRANT);
    assign transfer = (estado == GRANT) && acepta && req_valid[sel];
    assign fin      = req_last[sel] || (cuenta == CW'(MAX_RAFAGA - 1));

    // Ready depends only on grant and output-stage occupancy, never on req_valid.
    always_comb begin
        req_ready = 4'b0000;
        if ((estado == GRANT) && acepta) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= IDLE;
            sel       <= 2'd0;
            puntero   <= 2'd0;
            cuenta    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (hay_req) begin
                        sel    <= ganador;
                        cuenta <= '0;
                        estado <= GRANT;
                    end
                end
                GRANT: begin
                    if (transfer) begin
                        cuenta <= cuenta + 1'b1;
                        if (fin) begin
                            puntero <= sel + 2'd1;
                            estado  <= IDLE;
                        end
                    end
                end
                default: estado <= IDLE;
            endcase

            // A load wins over a consume so a simultaneous pair keeps out_valid high.
            if (transfer) begin
                out_data  <= dat_sel;
                out_last  <= fin;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/arbitro_rr_4.md
Name: arbitro_rr_4

Overview:
- Round-robin arbiter and sequencer that shares one ANCHO-bit output channel among four requesters (a, b, c, d).
- Each requester presents data with a valid/ready handshake.
- The block grants one requester at a time for a burst, drives the 2-bit select of the 4:1 selection internally, and registers the selected beat into a single output stage.
- It sits in front of any downstream consumer that accepts one stream of data.

Parameters:
ANCHO, 8, width of each requester data word and of out_data
MAX_RAFAGA, 4, maximum beats per grant (legal range 1..16)

Ports:
clk  input  1  clock; all registers rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  4  bit i: requester i has a beat (0=a, 1=b, 2=c, 3=d)
req_last  input  4  bit i: current beat of requester i ends its packet
dat_a  input  ANCHO  requester 0 data
dat_b  input  ANCHO  requester 1 data
dat_c  input  ANCHO  requester 2 data
dat_d  input  ANCHO  requester 3 data
req_ready  output  4  bit i: requester i beat accepted this cycle when high together with req_valid[i]
out_valid  output  1  out_data holds a beat
out_data  output  ANCHO  registered selected beat
out_last  output  1  beat closes the grant
out_ready  input  1  consumer accepts out_data
sel  output  2  index of current or last granted requester
ocupado  output  1  high while in state GRANT

Behaviour:
Reset (rst_n low, asynchronous, at any time including mid-burst):
- state=IDLE, sel=0, puntero=0, cuenta=0.
- out_valid=0, out_data=0, out_last=0, req_ready=0, ocupado=0.
- Any partially transferred burst is discarded; no beat is replayed after reset.

State IDLE:
- req_ready=0.
- If req_valid != 0: winner = first i with req_valid[i]=1, searching puntero, puntero+1, ... mod 4.
- Next edge: sel<=winner, cuenta<=0, state<=GRANT.
- The arbitration decision is registered, so there is exactly one cycle from request to grant.

State GRANT:
- ocupado=1.
- acepta = !out_valid || out_ready.
- req_ready[sel] = acepta; all other req_ready bits = 0. req_ready is combinational from state, sel, out_valid and out_ready only; it never depends on req_valid.
- Transfer occurs when req_valid[sel] && req_ready[sel]:
  - out_data <= dat_[sel]
  - out_valid <= 1
  - fin = req_last[sel] || (cuenta == MAX_RAFAGA-1)
  - out_last <= fin
  - cuenta <= cuenta+1
- If fin: puntero <= (sel+1) mod 4, state <= IDLE. sel keeps its value in IDLE.
- If req_valid[sel]=0: the grant is held with no timeout and other requesters wait. Requesters must not drop valid mid-packet except between beats.
- Throughput: 1 beat/cycle within a burst when out_ready=1. There is exactly one idle cycle between consecutive grants.

Output stage:
- out_valid && out_ready && no new load -> out_valid <= 0; out_data and out_last hold their values.
- out_valid && !out_ready -> out_data and out_last are stable and no new load occurs.
- Simultaneous consume and load -> the new beat replaces the old one and out_valid stays 1.

Burst cut:
- A packet longer than MAX_RAFAGA is cut: out_last=1 on beat MAX_RAFAGA.
- The remainder is sent on a later grant.
- MAX_RAFAGA=1 yields single-beat round-robin.

Width rules:
- cuenta is $clog2(MAX_RAFAGA+1) bits, minimum 1.
- puntero is 2 bits, wrap 3->0.

Test Plan:
- Reset, then req_valid=4'b0001, dat_a=8'h11, req_last=1, out_ready=1 -> sel=0 one cycle later; the next edge gives out_data=8'h11, out_valid=1, out_last=1; puntero=1.
- All four requesting continuously with single-beat packets (last=1), dat_a..d=8'hA0..8'hA3 -> out_data sequence A0, A1, A2, A3, A0, with one gap cycle between beats.
- Requester b sends a 6-beat packet with MAX_RAFAGA=4, while c is also requesting -> out_last on b's beat 4, then c is granted, then b's beats 5-6.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable, req_ready[sel]=0; on out_ready=1 the next beat loads in the same cycle with no loss or duplicate.
- Granted requester deasserts valid for 2 cycles mid-packet while d requests -> grant stays with the original sel; d does not get req_ready until that packet ends.
- rst_n pulsed low mid-burst (beat 2 of 4) -> all outputs 0 immediately, without a clock edge; after release, arbitration restarts from requester 0.
